axis_dc_restore: RTL and testbench
==================================

AXIS_DC_RESTORE -- requirements
Module: axis_dc_restore

Interface
REQ-001 SHALL have parameter S_AXIS_DATA_WIDTH, default 32: packed input word, {DC16, AC16}.
REQ-002 SHALL have parameter M_AXIS_DATA_WIDTH, default 16: reconstructed signed sample width.
REQ-003 SHALL have parameter SLEW_WIDTH, default 16: width of the DC slew-limit input.
REQ-004 SHALL provide port aclk, input, 1: the single clock.
REQ-005 SHALL provide port aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL provide port S_AXIS_tdata, input, 32: [31:16] signed DC, [15:0] signed AC.
REQ-007 SHALL provide port S_AXIS_tvalid, input, 1: input word valid.
REQ-008 SHALL provide port S_AXIS_tready, output, 1: block accepts the input word.
REQ-009 SHALL provide port dc_slew, input, SLEW_WIDTH: maximum DC change per accepted sample, unsigned; 0 disables slew limiting.
REQ-010 SHALL provide port dc_freeze, input, 1: hold the tracked DC.
REQ-011 SHALL provide port M_AXIS_tdata, output, 16: reconstructed AC+DC sample.
REQ-012 SHALL provide port M_AXIS_tvalid, output, 1: output sample valid.
REQ-013 SHALL provide port M_AXIS_tready, input, 1: downstream accepts the sample.
REQ-014 SHALL provide port ovf_count, output, 16: count of overflowed samples.
REQ-015 SHALL provide port state_dbg, output, 2: current FSM state encoding.

Function
REQ-016 SHALL treat an input transfer as S_AXIS_tvalid && S_AXIS_tready, and an output transfer as M_AXIS_tvalid && M_AXIS_tready.
REQ-017 SHALL drive S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready, giving a single-register pipeline with no bubble under continuous flow.
REQ-018 SHALL hold M_AXIS_tdata stable while M_AXIS_tvalid=1 and M_AXIS_tready=0.
REQ-019 SHALL present the output for an accepted input on the next cycle (latency 1).
REQ-020 SHALL drop M_AXIS_tvalid after an output transfer with no simultaneous input transfer.
REQ-021 SHALL keep a 16-bit signed dc_track register.
REQ-022 SHALL use FSM states INIT=0, TRACK=1, SLEW=2, HOLD=3, which advance only on input transfers.
REQ-023 INIT SHALL, on the first transfer, load dc_track with the input DC and go to TRACK.
REQ-024 With dc_freeze=1, every state except INIT SHALL go to HOLD with dc_track unchanged; dc_freeze takes priority over all other transitions.
REQ-025 TRACK, SLEW and HOLD (with dc_freeze=0) SHALL compute diff = DC − dc_track at 17 bits.
  - If dc_slew=0 or |diff| ≤ dc_slew: dc_track ← DC, next state TRACK.
  - Otherwise: dc_track ← dc_track ± dc_slew (sign of diff), next state SLEW.
REQ-026 SHALL form the output sum as AC + dc_track_next at 17 bits, where dc_track_next is the value after this transfer's update.
REQ-027 SHALL detect overflow when the sum is outside [−32768, 32767].

Reset
REQ-028 SHALL, while aresetn=0 (asynchronously), force M_AXIS_tvalid=0, M_AXIS_tdata=0, dc_track=0, ovf_count=0, state INIT and S_AXIS_tready=1.
REQ-029 SHALL discard any in-flight sample on reset mid-stream; the first transfer after release re-enters INIT behaviour.

Configuration
REQ-030 With DC_RESTORE_SAT_EN defined, an overflowing sum SHALL clamp to 32767 or −32768, and ovf_count SHALL increment once per overflowing transfer, saturating at 0xFFFF.
REQ-031 Without DC_RESTORE_SAT_EN, the output SHALL be the sum's low 16 bits (wrap), and ovf_count SHALL be constant 0.

Structure
REQ-032 Package axis_dc_pkg SHALL hold the state enum, the 16/17-bit width constants and the saturation limits.
REQ-033 SHALL place the slew/FSM/dc_track logic in sub-module dc_slew_limiter, with the top level holding the handshake, sum and saturation.

Verification
REQ-034 Reset, then input {0x0100, 0x0010} with M_AXIS_tready=1 -> next cycle M_AXIS_tdata=0x0110, state TRACK.
REQ-035 dc_track=0, dc_slew=0x10, input DC=0x0040, AC=0 for 4 transfers -> outputs 0x10, 0x20, 0x30, 0x40; state SLEW, SLEW, SLEW, TRACK.
REQ-036 dc_freeze=1, then DC changed to 0x7000 -> output equals AC + old dc_track, state HOLD; after release the first transfer resumes tracking.
REQ-037 DC=0x7F00, AC=0x0200 -> output 0x7FFF with ovf_count=1 when DC_RESTORE_SAT_EN is defined; 0x8100 with ovf_count=0 when it is not.
REQ-038 M_AXIS_tready=0 for 5 cycles with S_AXIS_tvalid=1 -> S_AXIS_tready=0 and output stable; on release there is no loss or duplication.
REQ-039 aresetn pulsed low mid-stream -> M_AXIS_tvalid=0 immediately, and the next transfer reloads DC directly (INIT).

Source files
------------

// File: rtl/axis_dc_pkg.sv
// ============================================================================
// axis_dc_pkg : shared widths, saturation limits and tracker state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package axis_dc_pkg;

  localparam int DATA_W = 16;
  localparam int SUM_W  = 17;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_SLEW  = 2'd2,
    ST_HOLD  = 2'd3
  } dc_state_e;

endpackage

`default_nettype wire

// File: rtl/axis_dc_restore_if.sv
// ============================================================================
// axis_dc_restore_if : AXI-Stream data/valid/ready bundle with master/slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface axis_dc_restore_if
  import axis_dc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);

endinterface

`default_nettype wire

// File: rtl/axis_dc_restore_dc_slew_limiter.sv
// ============================================================================
// dc_slew_limiter : slew-limited DC tracker FSM, advancing only on input transfers
// Rev 1.0
// ============================================================================
`default_nettype none

module dc_slew_limiter
  import axis_dc_pkg::*;
#(
  parameter int SLEW_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     xfer_i,
  input  logic signed [DATA_W-1:0] dc_i,
  input  logic [SLEW_WIDTH-1:0]    slew_i,
  input  logic                     freeze_i,
  output logic signed [DATA_W-1:0] dc_next_o,
  output dc_state_e                state_o
);

  localparam int CMP_W = (SLEW_WIDTH > SUM_W) ? SLEW_WIDTH : SUM_W;

  dc_state_e                state_q, state_d;
  logic signed [DATA_W-1:0] dc_q, dc_d;
  logic [SUM_W-1:0]         track_ext;
  logic [SUM_W-1:0]         diff;
  logic [SUM_W-1:0]         diff_mag;
  logic [CMP_W-1:0]         mag_ext;
  logic [CMP_W-1:0]         slew_ext;
  logic [SUM_W-1:0]         step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dc_d      = dc_q;
    track_ext = {dc_q[DATA_W-1], dc_q};
    diff      = {dc_i[DATA_W-1], dc_i} - track_ext;
    diff_mag  = diff[SUM_W-1] ? (17'd0 - diff) : diff;
    mag_ext   = CMP_W'(diff_mag);
    slew_ext  = CMP_W'(slew_i);
    // A step only happens when slew < |diff| <= 65535, so the low 17 bits hold it exactly.
    step      = slew_ext[SUM_W-1:0];

    if (xfer_i) begin
      case (state_q)
        ST_INIT: begin
          dc_d    = dc_i;
          state_d = ST_TRACK;
        end
        default: begin
          if (freeze_i) begin
            state_d = ST_HOLD;
          end else if ((slew_ext == '0) || (mag_ext <= slew_ext)) begin
            dc_d    = dc_i;
            state_d = ST_TRACK;
          end else begin
            dc_d    = diff[SUM_W-1] ? DATA_W'(track_ext - step) : DATA_W'(track_ext + step);
            state_d = ST_SLEW;
          end
        end
      endcase
    end
  end

  assign dc_next_o = dc_d;
  assign state_o   = state_q;

endmodule

`default_nettype wire

// File: rtl/axis_dc_restore.sv
// ============================================================================
// axis_dc_restore : AXI-Stream {DC,AC} -> AC+DC sample with slew-limited DC track
// Rev 1.0 ; define DC_RESTORE_SAT_EN for saturating output and overflow counting
// ============================================================================
`default_nettype none

module axis_dc_restore
  import axis_dc_pkg::*;
#(
  parameter int S_AXIS_DATA_WIDTH = 32,
  parameter int M_AXIS_DATA_WIDTH = 16,
  parameter int SLEW_WIDTH        = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  output logic                         S_AXIS_tready,
  input  logic [SLEW_WIDTH-1:0]        dc_slew,
  input  logic                         dc_freeze,
  output logic [M_AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic [15:0]                  ovf_count,
  output logic [1:0]                   state_dbg
);

  logic signed [DATA_W-1:0] in_dc;
  logic signed [DATA_W-1:0] in_ac;
  logic signed [DATA_W-1:0] dc_next;
  logic [DATA_W-1:0]        out_d;
  logic [DATA_W-1:0]        m_data_q;
  logic                     m_valid_q;
  logic                     in_xfer;
  dc_state_e                state;

  assign in_dc         = S_AXIS_tdata[2*DATA_W-1:DATA_W];
  assign in_ac         = S_AXIS_tdata[DATA_W-1:0];
  assign S_AXIS_tready = !m_valid_q || M_AXIS_tready;
  assign in_xfer       = S_AXIS_tvalid && S_AXIS_tready;

  dc_slew_limiter #(
    .SLEW_WIDTH (SLEW_WIDTH)
  ) u_slew (
    .clk       (aclk),
    .rst_n     (aresetn),
    .xfer_i    (in_xfer),
    .dc_i      (in_dc),
    .slew_i    (dc_slew),
    .freeze_i  (dc_freeze),
    .dc_next_o (dc_next),
    .state_o   (state)
  );

`ifdef DC_RESTORE_SAT_EN
  logic [SUM_W-1:0] sum;
  logic             ovf;
  logic [15:0]      ovf_q;

  assign sum   = {in_ac[DATA_W-1], in_ac} + {dc_next[DATA_W-1], dc_next};
  assign ovf   = sum[SUM_W-1] ^ sum[DATA_W-1];
  assign out_d = ovf ? (sum[SUM_W-1] ? SAT_MIN : SAT_MAX) : sum[DATA_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_q <= '0;
    end else if (in_xfer && ovf && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_count = ovf_q;
`else
  assign out_d     = in_ac + dc_next;
  assign ovf_count = '0;
`endif

  // A new input always overwrites the slot: it is only accepted when the slot is empty or draining.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (in_xfer) begin
      m_valid_q <= 1'b1;
      m_data_q  <= out_d;
    end else if (M_AXIS_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign M_AXIS_tvalid = m_valid_q;
  assign M_AXIS_tdata  = M_AXIS_DATA_WIDTH'(m_data_q);
  assign state_dbg     = state;

endmodule

`default_nettype wire

// File: tb/tb_axis_dc_restore.sv
// ============================================================================
// tb_axis_dc_restore : directed self-checking bench for axis_dc_restore
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axis_dc_restore;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] dc_slew;
  logic        dc_freeze;
  logic [15:0] ovf_count;
  logic [1:0]  state_dbg;
  int          total = 0;
  int          bad   = 0;

`ifdef DC_RESTORE_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
  localparam logic [15:0] EXP_CNT1    = 16'd1;
  localparam logic [15:0] EXP_CNT2    = 16'd2;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8100;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_CNT1    = 16'd0;
  localparam logic [15:0] EXP_CNT2    = 16'd0;
`endif

  axis_dc_restore_if #(.DATA_WIDTH(32)) s_if ();
  axis_dc_restore_if #(.DATA_WIDTH(16)) m_if ();

  axis_dc_restore dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .S_AXIS_tdata  (s_if.tdata),
    .S_AXIS_tvalid (s_if.tvalid),
    .S_AXIS_tready (s_if.tready),
    .dc_slew       (dc_slew),
    .dc_freeze     (dc_freeze),
    .M_AXIS_tdata  (m_if.tdata),
    .M_AXIS_tvalid (m_if.tvalid),
    .M_AXIS_tready (m_if.tready),
    .ovf_count     (ovf_count),
    .state_dbg     (state_dbg)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] dc, input logic [15:0] ac);
    @(negedge aclk);
    s_if.tdata  = {dc, ac};
    s_if.tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] data, input logic [1:0] st);
    check({tag, "_valid"}, 32'(m_if.tvalid), 32'd1);
    check({tag, "_data"},  32'(m_if.tdata),  32'(data));
    check({tag, "_state"}, 32'(state_dbg),   32'(st));
  endtask

  initial begin
    aresetn     = 1'b0;
    dc_slew     = 16'd0;
    dc_freeze   = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;

    repeat (3) @(negedge aclk);
    check("rst_valid",  32'(m_if.tvalid), 32'd0);
    check("rst_data",   32'(m_if.tdata),  32'd0);
    check("rst_ovf",    32'(ovf_count),   32'd0);
    check("rst_state",  32'(state_dbg),   32'd0);
    check("rst_sready", 32'(s_if.tready), 32'd1);
    aresetn = 1'b1;

    // First transfer loads the DC directly.
    send(16'h0100, 16'h0010);
    expect_out("init", 16'h0110, 2'd1);

    // Bring the track to 0, then slew toward 0x40 in 0x10 steps.
    send(16'h0000, 16'h0005);
    expect_out("zero", 16'h0005, 2'd1);
    dc_slew = 16'h0010;
    send(16'h0040, 16'h0000);
    expect_out("slew1", 16'h0010, 2'd2);
    send(16'h0040, 16'h0000);
    expect_out("slew2", 16'h0020, 2'd2);
    send(16'h0040, 16'h0000);
    expect_out("slew3", 16'h0030, 2'd2);
    send(16'h0040, 16'h0000);
    expect_out("slew4", 16'h0040, 2'd1);

    // Freeze holds the old DC regardless of the input DC.
    dc_freeze = 1'b1;
    send(16'h7000, 16'h0003);
    expect_out("hold1", 16'h0043, 2'd3);
    send(16'h7000, 16'h0001);
    expect_out("hold2", 16'h0041, 2'd3);
    dc_freeze = 1'b0;
    send(16'h7000, 16'h0000);
    expect_out("resume_slew", 16'h0050, 2'd2);
    dc_slew = 16'h0000;
    send(16'h7000, 16'h0000);
    expect_out("resume_track", 16'h7000, 2'd1);

    // Overflow in both directions, then an in-range extreme value.
    send(16'h7F00, 16'h0200);
    expect_out("ovf_pos", EXP_POS_OVF, 2'd1);
    check("ovf_cnt1", 32'(ovf_count), 32'(EXP_CNT1));
    send(16'h8000, 16'hFFFF);
    expect_out("ovf_neg", EXP_NEG_OVF, 2'd1);
    check("ovf_cnt2", 32'(ovf_count), 32'(EXP_CNT2));
    send(16'h8000, 16'h0000);
    expect_out("min_ok", 16'h8000, 2'd1);
    check("ovf_cnt3", 32'(ovf_count), 32'(EXP_CNT2));

    // Output drains when no new input arrives.
    @(posedge aclk);
    #1;
    check("drain_valid", 32'(m_if.tvalid), 32'd0);

    // Backpressure: one sample accepted, the next waits, nothing lost or repeated.
    @(negedge aclk);
    m_if.tready = 1'b0;
    s_if.tdata  = {16'h0000, 16'h0011};
    s_if.tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_if.tdata = {16'h0000, 16'h0022};
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_sready", 32'(s_if.tready), 32'd0);
      check("bp_valid",  32'(m_if.tvalid), 32'd1);
      check("bp_data",   32'(m_if.tdata),  32'h0011);
    end
    m_if.tready = 1'b1;
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    check("bp_next_valid", 32'(m_if.tvalid), 32'd1);
    check("bp_next_data",  32'(m_if.tdata),  32'h0022);
    @(posedge aclk);
    #1;
    check("bp_end_valid", 32'(m_if.tvalid), 32'd0);

    // Asynchronous reset mid-stream discards the pending sample and re-enters INIT.
    send(16'h0100, 16'h0001);
    expect_out("pre_rst", 16'h0101, 2'd1);
    @(negedge aclk);
    s_if.tdata  = {16'h0300, 16'h0000};
    s_if.tvalid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_valid",  32'(m_if.tvalid), 32'd0);
    check("arst_data",   32'(m_if.tdata),  32'd0);
    check("arst_state",  32'(state_dbg),   32'd0);
    check("arst_sready", 32'(s_if.tready), 32'd1);
    check("arst_ovf",    32'(ovf_count),   32'd0);
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    dc_slew = 16'h0010;
    send(16'h0200, 16'h0003);
    expect_out("post_rst", 16'h0203, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
